// File: rtl/mux_scan_seq_pkg.sv
// mux_scan_seq_pkg: shared channel-count, index-width and FSM state constants for the mux select sequencer
package mux_scan_seq_pkg;
  localparam int NCH = 8;
  localparam int CH_W = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, FIN = 2'd2} state_t;
endpackage

// File: rtl/mux_scan_next.sv
// mux_scan_next: lowest enabled channel above cur (or from 0 when first); ports mask, cur, first in; nxt, found out
module mux_scan_next
  import mux_scan_seq_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [CH_W-1:0] cur,
  input  logic            first,
  output logic [CH_W-1:0] nxt,
  output logic            found
);
  logic [NCH-1:0] cand;
  always_comb begin
    cand = first ? mask : mask & ~((NCH'(2) << cur) - NCH'(1));
    nxt = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        nxt = CH_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_scan_seq.sv
// mux_scan_seq: dwell-timed ascending walk of enabled 8:1 mux channels; ports clk, rst, start, abort, chan_mask, dwell in; x, s0-s3, chan, sample_valid, busy, done out
module mux_scan_seq
  import mux_scan_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [NCH-1:0]     chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic               x,
  output logic               s0,
  output logic               s1,
  output logic               s2,
  output logic               s3,
  output logic [CH_W-1:0]    chan,
  output logic               sample_valid,
  output logic               busy,
  output logic               done
);
  state_t state, state_d;
  logic [DWELL_W-1:0] cnt, cnt_d, dwell_q, dwell_eff;
  logic [NCH-1:0] mask_q;
  logic [CH_W-1:0] chan_d, nxt;
  logic found, in_hold;
  assign in_hold = state == HOLD;
  assign dwell_eff = dwell == '0 ? DWELL_W'(1) : dwell;
  assign x = chan[2];
  assign s0 = chan[0];
  assign s1 = chan[1];
  assign s2 = chan[0];
  assign s3 = chan[1];
  mux_scan_next u_next (
    .mask (in_hold ? mask_q : chan_mask),
    .cur  (chan),
    .first(!in_hold),
    .nxt  (nxt),
    .found(found)
  );
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    chan_d = chan;
    if (in_hold) begin
      if (abort) state_d = IDLE;
      else if (cnt > DWELL_W'(1)) cnt_d = cnt - DWELL_W'(1);
      else if (found) begin
        chan_d = nxt;
        cnt_d = dwell_q;
      end else state_d = FIN;
    end else if (start) begin
      state_d = found ? HOLD : FIN;
      chan_d = found ? nxt : chan;
      cnt_d = found ? dwell_eff : cnt;
    end else state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      chan <= '0;
      mask_q <= '0;
      dwell_q <= '0;
      sample_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      chan <= chan_d;
      if (!in_hold && start) begin
        mask_q <= chan_mask;
        dwell_q <= dwell_eff;
      end
      sample_valid <= state_d == HOLD && cnt_d == DWELL_W'(1);
      busy <= state_d == HOLD;
      done <= state_d == FIN;
    end
  end
endmodule
